// File: rtl/checking_pkg.sv
// Shared constants and helpers for the sequence-checking FIFO.
package checking_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    localparam int ERR_W     = 8;

    // Saturating increment used by the error counter.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO: storage, pointers and occupancy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // Flags come straight from the occupancy register, never from the inputs.
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push    = wr_en_i & ~full_o;
    assign pop     = rd_en_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/checking.sv
// FIFO with an inline checker that flags non-consecutive words on the write side.
module checking
    import checking_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_rts,
    output logic             full,
    output logic [WIDTH-1:0] data_out,
    input  logic             out_rtr,
    input  logic             rst_,
    output logic             out_rts,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    logic             empty;
    logic             wr_accept;
    logic             exp_valid_q, exp_valid_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_      (rst_),
        .wr_en_i   (in_rts),
        .wr_data_i (data_in),
        .rd_en_i   (out_rtr),
        .rd_data_o (data_out),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign out_rts   = ~empty;
    assign wr_accept = in_rts & ~full;

    // The first accepted word only seeds the expectation; later ones are compared.
    always_comb begin
        exp_valid_d = exp_valid_q;
        exp_d       = exp_q;
        seq_err_d   = seq_err_q;
        err_count_d = err_count_q;
        if (wr_accept) begin
            exp_valid_d = 1'b1;
            exp_d       = data_in + 1'b1;
            if (exp_valid_q && (data_in != exp_q)) begin
                seq_err_d   = 1'b1;
                err_count_d = sat_inc(err_count_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            exp_valid_q <= 1'b0;
            exp_q       <= '0;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            exp_valid_q <= exp_valid_d;
            exp_q       <= exp_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_checking.sv
// Directed, table-driven bench for the checking FIFO plus hand-written corner cases.
module tb_checking;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic [7:0] data_in = '0;
    logic       in_rts = 1'b0;
    logic       out_rtr = 1'b0;
    logic       full;
    logic [7:0] data_out;
    logic       out_rts;
    logic       seq_err;
    logic [7:0] err_count;

    int passCount = 0;
    int checkCount = 0;

    typedef struct {
        bit         doRst;
        bit         wr;
        bit         rd;
        logic [7:0] data;
        bit         eFull;
        bit         eRts;
        logic [7:0] eDout;
        bit         eErr;
        logic [7:0] eCnt;
    } vec_t;

    vec_t vecs[$];

    checking #(.WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .data_in   (data_in),
        .in_rts    (in_rts),
        .full      (full),
        .data_out  (data_out),
        .out_rtr   (out_rtr),
        .rst_      (rst_),
        .out_rts   (out_rts),
        .seq_err   (seq_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit w, bit rd, logic [7:0] d, bit f, bit rts,
                                logic [7:0] o, bit e, logic [7:0] c);
        vec_t v;
        v.doRst = r; v.wr = w; v.rd = rd; v.data = d;
        v.eFull = f; v.eRts = rts; v.eDout = o; v.eErr = e; v.eCnt = c;
        return v;
    endfunction

    task automatic cmp(string name, int got, int want);
        checkCount++;
        if (got == want) passCount++;
        else $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    endtask

    task automatic checkOutput(string tag, bit f, bit rts, logic [7:0] o, bit e, logic [7:0] c);
        cmp({tag, ".full"}, full, f);
        cmp({tag, ".out_rts"}, out_rts, rts);
        cmp({tag, ".data_out"}, data_out, o);
        cmp({tag, ".seq_err"}, seq_err, e);
        cmp({tag, ".err_count"}, err_count, c);
    endtask

    // One clock cycle of stimulus; outputs are sampled 1ns after the rising edge.
    task automatic applyStimulus(bit w, bit rd, logic [7:0] d);
        @(negedge clk);
        in_rts  = w;
        out_rtr = rd;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic assertReset();
        @(negedge clk);
        #2;
        rst_    = 1'b0;
        in_rts  = 1'b0;
        out_rtr = 1'b0;
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        int satModel;
        // Fill to full, refuse, pop-while-full, then drain in order.
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 1, 0, 8'(i), i == 15, 1, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h77, 1, 1, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h77, 0, 1, 8'h01, 0, 0));
        for (int k = 1; k < 16; k++)
            vecs.push_back(mk(0, 0, 1, 8'h00, 0, k < 15, (k < 15) ? 8'(k + 1) : 8'h00, 0, 0));
        // Sequence 5,6,9,10 streamed through with simultaneous pops.
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h05, 0, 1, 8'h05, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h06, 0, 1, 8'h06, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h09, 0, 1, 8'h09, 1, 1));
        vecs.push_back(mk(0, 1, 1, 8'h0A, 0, 1, 8'h0A, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 8'h00, 1, 1));
        // Wrap 0xFE,0xFF,0x00 is sequential.
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hFE, 0, 1, 8'hFE, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 0, 1, 8'hFF, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doRst) begin
                assertReset();
                checkOutput($sformatf("v%0d", i), vecs[i].eFull, vecs[i].eRts,
                            vecs[i].eDout, vecs[i].eErr, vecs[i].eCnt);
                releaseReset();
            end else begin
                applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].data);
                checkOutput($sformatf("v%0d", i), vecs[i].eFull, vecs[i].eRts,
                            vecs[i].eDout, vecs[i].eErr, vecs[i].eCnt);
            end
        end

        // Write and pop on an empty FIFO: the pop is ignored, word appears next cycle.
        assertReset();
        releaseReset();
        applyStimulus(1, 1, 8'h20);
        checkOutput("ffwt.w", 0, 1, 8'h20, 0, 0);
        applyStimulus(0, 0, 8'h00);
        checkOutput("ffwt.hold", 0, 1, 8'h20, 0, 0);
        applyStimulus(0, 1, 8'h00);
        checkOutput("ffwt.pop", 0, 0, 8'h00, 0, 0);

        // Repeated zeros: every write after the first is an error; counter saturates.
        assertReset();
        releaseReset();
        satModel = 0;
        for (int i = 0; i < 258; i++) begin
            applyStimulus(1, 1, 8'h00);
            if (i > 0 && satModel < 255) satModel++;
            cmp($sformatf("sat%0d.err_count", i), err_count, satModel);
        end
        cmp("sat.seq_err", seq_err, 1);

        // Reset dropped between edges with 8 words stored clears everything at once.
        assertReset();
        releaseReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 8'(2 * i));
        checkOutput("mid.pre", 0, 1, 8'h00, 1, 7);
        @(negedge clk);
        #2;
        rst_ = 1'b0;
        in_rts = 1'b0;
        #1;
        checkOutput("mid.rst", 0, 0, 8'h00, 0, 0);
        releaseReset();
        applyStimulus(1, 0, 8'h55);
        checkOutput("mid.post", 0, 1, 8'h55, 0, 0);
        applyStimulus(1, 0, 8'h99);
        checkOutput("mid.err", 0, 1, 8'h55, 1, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/checking.md
CHECKING -- requirements
Module: checking

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, FIFO depth in words; power of two, at least 2.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_  input  1  reset; asynchronous, active-low.
REQ-005 data_in  input  WIDTH  upstream write data.
REQ-006 in_rts  input  1  upstream ready-to-send; a write is requested in this cycle.
REQ-007 full  output  1  FIFO holds DEPTH words; upstream writes are refused.
REQ-008 data_out  output  WIDTH  head-of-FIFO word (first-word fall-through).
REQ-009 out_rtr  input  1  downstream ready-to-receive; the head word is popped in this cycle.
REQ-010 out_rts  output  1  FIFO not empty; data_out is valid.
REQ-011 seq_err  output  1  sticky flag: a non-sequential input word was accepted.
REQ-012 err_count  output  8  number of sequence errors, saturating at 255.
REQ-013 Port order: clk, data_in, in_rts, full, data_out, out_rtr, rst_, out_rts, seq_err, err_count.

Function
REQ-014 Write accepted = in_rts AND NOT full; the word is stored at the tail in that cycle.
REQ-015 Pop = out_rtr AND out_rts; the head advances in that cycle.
REQ-016 When full, a write is refused even if a pop occurs in the same cycle.
REQ-017 When empty, out_rtr is ignored; a same-cycle write makes the word visible on the next cycle.
REQ-018 Simultaneous accepted write and pop leaves the occupancy unchanged.
REQ-019 Occupancy counter is $clog2(DEPTH)+1 bits wide; read and write pointers wrap modulo DEPTH.
REQ-020 full = (occupancy == DEPTH); out_rts = (occupancy != 0); both are registered-state derived with no combinational path from the inputs.
REQ-021 data_out = memory at the read pointer when out_rts = 1; otherwise data_out = 0.
REQ-022 Sequence checker: the first accepted write after reset loads the expected register with data_in+1 (mod 2^WIDTH) and raises no error.
REQ-023 Each subsequent accepted write compares data_in with expected.
REQ-024 On mismatch, seq_err is set, err_count increments (saturating), and expected resyncs to data_in+1.
REQ-025 On match, expected becomes data_in+1.
REQ-026 Wrap from 2^WIDTH-1 to 0 counts as sequential.
REQ-027 Refused writes (full) are not checked.
REQ-028 Data is stored and forwarded regardless of the checker result.

Reset
REQ-029 rst_ low asynchronously clears pointers, occupancy, seq_err, err_count, the expected-valid flag, and the expected value.
REQ-030 Reset values: full=0, out_rts=0, data_out=0, seq_err=0, err_count=0.
REQ-031 FIFO memory contents are not reset.
REQ-032 Reset mid-operation discards all stored words.
REQ-033 Release of rst_ is synchronous to clk at the next edge.

Structure
REQ-034 A shared package holds the default WIDTH, DEPTH, and error-count width constants.
REQ-035 The design has one sub-module, sync_fifo (storage, pointers, full/empty).
REQ-036 The sequence checker lives in the checking top level.

Verification
REQ-037 Reset, then in_rts=1 with data_in = 0,1,2,...,15 and out_rtr=0 -> full=1 after the 16th write; 17th word refused; seq_err=0.
REQ-038 From full, out_rtr=1 for 16 cycles -> data_out = 0..15 in order; out_rts=0 afterwards; data_out=0.
REQ-039 Empty FIFO, in_rts and out_rtr high together with data 0x20 -> out_rts=1 and data_out=0x20 on the next cycle; no pop on the first cycle.
REQ-040 Accepted sequence 5,6,9,10 -> seq_err=1, err_count=1 after 9; 10 causes no further error.
REQ-041 Accepted sequence 0xFE,0xFF,0x00 -> seq_err stays 0.
REQ-042 Drop rst_ while 8 words are stored, then release -> full=0, out_rts=0, err_count=0, and the next write raises no error.
